// File: rtl/mem_wb_stage_pkg.sv
// mem_wb_stage_pkg: load-type encodings shared by the decoder and the write-back stage
package mem_wb_stage_pkg;

    typedef enum logic [2:0] {
        LT_LW  = 3'b000,
        LT_LH  = 3'b001,
        LT_LHU = 3'b010,
        LT_LB  = 3'b011,
        LT_LBU = 3'b100
    } load_type_e;

    // Halfword loads need offset[0]=0; word loads (and unknown codes, treated as word) need offset 00.
    function automatic logic is_misaligned(input logic [2:0] lt, input logic [1:0] offset);
        return (lt == LT_LH || lt == LT_LHU) ? offset[0] :
               (lt == LT_LB || lt == LT_LBU) ? 1'b0 : (offset != 2'b00);
    endfunction

endpackage

// File: rtl/mem_wb_stage_load_extract.sv
// load_extract: picks the addressed byte/half out of a little-endian memory word and extends it
module load_extract
    import mem_wb_stage_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [2:0]      load_type,
    input  logic [1:0]      offset,
    input  logic [XLEN-1:0] read_data,
    output logic [XLEN-1:0] data
);

    logic [15:0] half;
    logic [7:0]  bt;

    // Lane selection by offset, then sign or zero extension by load type
    always_comb begin
        half = offset[1] ? read_data[31:16] : read_data[15:0];
        bt   = offset == 2'd0 ? read_data[7:0] :
               offset == 2'd1 ? read_data[15:8] :
               offset == 2'd2 ? read_data[23:16] : read_data[31:24];
        data = load_type == LT_LH  ? {{(XLEN-16){half[15]}}, half} :
               load_type == LT_LHU ? {{(XLEN-16){1'b0}}, half} :
               load_type == LT_LB  ? {{(XLEN-8){bt[7]}}, bt} :
               load_type == LT_LBU ? {{(XLEN-8){1'b0}}, bt} : read_data;
    end

endmodule

// File: rtl/mem_wb_stage.sv
// mem_wb_stage: MEM/WB pipeline register with load extraction, retire counter and misalignment flag
module mem_wb_stage
    import mem_wb_stage_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             mem_valid,
    input  logic [XLEN-1:0]  mem_alu_result,
    input  logic [XLEN-1:0]  mem_read_data,
    input  logic [4:0]       mem_dest_reg,
    input  logic             mem_reg_write,
    input  logic             mem_mem_to_reg,
    input  logic [2:0]       mem_load_type,
    input  logic             stall_wb,
    input  logic             flush_wb,
    output logic [4:0]       WriteRegister,
    output logic [XLEN-1:0]  WriteData,
    output logic             regWrite,
    output logic             wb_valid,
    output logic [CNT_W-1:0] retired_count,
    output logic             misalign_err
);

    logic [XLEN-1:0] load_data;
    logic [XLEN-1:0] next_data;
    logic            misaligned;
    logic            next_write;

    load_extract #(.XLEN(XLEN)) u_extract (
        .load_type (mem_load_type),
        .offset    (mem_alu_result[1:0]),
        .read_data (mem_read_data),
        .data      (load_data)
    );

    // Result selection and write qualification happen before the register, so outputs are flop-driven
    always_comb begin
        misaligned = mem_mem_to_reg && is_misaligned(mem_load_type, mem_alu_result[1:0]);
        next_data  = mem_mem_to_reg ? load_data : mem_alu_result;
        next_write = mem_valid && mem_reg_write && (mem_dest_reg != 5'd0) && !misaligned;
    end

    // Flush kills the incoming slot even during a stall; a plain stall holds everything
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wb_valid      <= 1'b0;
            regWrite      <= 1'b0;
            WriteRegister <= '0;
            WriteData     <= '0;
            retired_count <= '0;
            misalign_err  <= 1'b0;
        end else if (flush_wb) begin
            wb_valid <= 1'b0;
            regWrite <= 1'b0;
        end else if (!stall_wb) begin
            wb_valid      <= mem_valid;
            regWrite      <= next_write;
            WriteRegister <= mem_dest_reg;
            WriteData     <= next_data;
            if (mem_valid)
                retired_count <= retired_count + CNT_W'(1);
            if (mem_valid && misaligned)
                misalign_err <= 1'b1;
        end
    end

endmodule

// File: doc/mem_wb_stage.md
MEM_WB_STAGE -- requirements
Module: mem_wb_stage

Interface
REQ-001 SHALL have parameter XLEN, default 32, datapath width.
REQ-002 SHALL have parameter CNT_W, default 32, width of the retired-instruction counter.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 mem_valid  input  1  MEM stage holds a valid instruction.
REQ-006 mem_alu_result  input  XLEN  ALU result / load address; bits [1:0] are the byte offset.
REQ-007 mem_read_data  input  XLEN  raw aligned word from data memory, little-endian.
REQ-008 mem_dest_reg  input  5  destination register index.
REQ-009 mem_reg_write  input  1  instruction writes a register.
REQ-010 mem_mem_to_reg  input  1  1 = load result, 0 = ALU result.
REQ-011 mem_load_type  input  3  000 LW, 001 LH, 010 LHU, 011 LB, 100 LBU; other codes are treated as LW.
REQ-012 stall_wb  input  1  hold current WB contents.
REQ-013 flush_wb  input  1  discard the incoming instruction.
REQ-014 WriteRegister  output  5  register-file write index.
REQ-015 WriteData  output  XLEN  register-file write data.
REQ-016 regWrite  output  1  register-file write enable.
REQ-017 wb_valid  output  1  WB stage holds a valid instruction.
REQ-018 retired_count  output  CNT_W  count of captured valid instructions.
REQ-019 misalign_err  output  1  sticky misaligned-load flag.

Function
REQ-020 SHALL capture MEM inputs into WB registers on each rising edge when stall_wb=0; outputs reflect an instruction exactly one cycle after capture.
REQ-021 SHALL hold all WB registers and outputs unchanged while stall_wb=1 and flush_wb=0.
REQ-022 SHALL load wb_valid=0 on an edge with flush_wb=1, regardless of stall_wb (flush wins).
REQ-023 SHALL select the extracted load data when mem_mem_to_reg=1, otherwise mem_alu_result; selection and extraction are done before capture, so WriteData is a register output.
REQ-024 LW: WriteData = mem_read_data.
REQ-025 LH/LHU: select half [15:0] if offset[1]=0 else [31:16]; sign-extend for LH, zero-extend for LHU.
REQ-026 LB/LBU: select byte at offset[1:0] (offset 0 = bits [7:0]); sign-extend for LB, zero-extend for LBU.
REQ-027 Misaligned load: mem_mem_to_reg=1 and (LW with offset!=00, or LH/LHU with offset[0]=1).
REQ-028 A captured misaligned valid load SHALL be captured with regWrite=0 and SHALL set misalign_err, which stays 1 until reset.
REQ-029 regWrite SHALL equal wb_valid AND captured mem_reg_write AND (captured dest != 0) AND not misaligned.
REQ-030 While stalled, regWrite SHALL remain at its held value (rewriting the same data is permitted).
REQ-031 retired_count SHALL increment by 1 on each edge that captures mem_valid=1 with stall_wb=0 and flush_wb=0, misaligned loads included.
REQ-032 retired_count SHALL wrap from all-ones to 0.
REQ-033 Non-load (mem_mem_to_reg=0) SHALL never set misalign_err.

Reset
REQ-034 On reset low, SHALL asynchronously clear wb_valid, regWrite, WriteRegister, WriteData, retired_count and misalign_err to 0.
REQ-035 An instruction in flight at reset assertion SHALL be discarded; the first capture after reset deasserts occurs on the first rising edge with reset high.

Structure
REQ-036 SHALL place the load_type encodings (LW, LH, LHU, LB, LBU) in a shared package also used by the decoder.
REQ-037 SHALL implement byte/half extraction and extension as one combinational sub-module, load_extract.

Verification
REQ-038 LB, offset 11, mem_read_data=0x80FF_1234 -> next cycle WriteData=0xFFFF_FF80, regWrite=1.
REQ-039 LHU, offset 10, mem_read_data=0x8001_0000 -> WriteData=0x0000_8001; LH at the same address -> 0xFFFF_8001.
REQ-040 LW, offset 01, dest 5 -> regWrite=0, misalign_err=1 and held through 10 further cycles; retired_count increments by 1.
REQ-041 ALU op with dest 0 and value 0x1234 -> regWrite=0, wb_valid=1; ALU op with dest 9 and value 100 -> WriteRegister=9, WriteData=100, regWrite=1.
REQ-042 stall_wb=1 and flush_wb=1 on the same edge with mem_valid=1 -> wb_valid=0, retired_count unchanged; stall alone for 3 cycles -> outputs frozen and the count is not incremented.
REQ-043 Preload retired_count to all-ones via captured instructions (or force), then capture 1 -> count=0; assert reset mid-stream -> all outputs 0 immediately, without waiting for a clock edge.
